muldiv_seq: RTL and testbench
=============================

# muldiv_seq

Parametrised, multi-cycle RV32M/RV64M-style multiply/divide unit that replaces the single-cycle combinational mul/div/rem path of the execute-stage ALU. It computes one result bit per cycle: a shift-add multiplier and a restoring divider share a single datapath. Valid/ready handshakes on both the request and response sides let the pipeline stall on it. A flush input lets the pipeline kill the operation on a branch mispredict or trap. It also handles the RISC-V divide-by-zero and signed-overflow corner results in short latency and flags both conditions.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  unit can accept a request; high only in IDLE.
- op  in  3  funct3 encoding:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- a  in  XLEN  rs1 operand.
- b  in  XLEN  rs2 operand.
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  selected product half, quotient, or remainder.
- div_zero  out  1  with out_valid: the operation was a div/rem with b == 0.
- div_ovf  out  1  with out_valid: the operation was DIV/REM with a == -2^(XLEN-1) and b == -1.

## Operation
- **States:** IDLE, BUSY, DONE.
- **Reset values (rst_n low at an edge):**
  - State goes to IDLE; counter is 0.
  - out_valid = 0, result = 0, div_zero = 0, div_ovf = 0, in_ready = 1 on the following cycle.
- **Accept:** in IDLE with in_valid & !flush, latch op.
  - Signed ops (MULH, DIV, REM, and the rs1 of MULHSU): operands are converted to magnitude and the sign flags are stored.
  - MUL uses unsigned magnitudes directly; its low half is sign-agnostic.
- **Special cases, detected at accept:**
  - div/rem with b == 0 -> DONE directly.
    - Quotient = all ones (both DIV and DIVU).
    - Remainder = a.
    - div_zero = 1.
  - DIV/REM signed overflow -> DONE directly.
    - Quotient = a.
    - Remainder = 0.
    - div_ovf = 1.
  - Otherwise -> BUSY with counter = XLEN.
- **BUSY:** one iteration per cycle; the counter decrements; at counter == 1 the next state is DONE.
  - Multiply: a 2·XLEN accumulator, conditional add of the multiplicand, shift right.
  - Divide: restoring divider; shift the remainder left, trial-subtract the divisor, and set the quotient bit when the result is non-negative.
- **Transition to DONE:** apply sign correction, then register result.
  - Product: negated if the operand signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
  - MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- **DONE:** out_valid = 1.
  - result and flags are held stable until out_valid & out_ready.
  - On that handshake the unit goes to IDLE.
- **flush:** in any state, next state is IDLE and out_valid drops the next cycle.
  - flush in the same cycle as in_valid: the request is not accepted.
  - flush in DONE the same cycle as out_ready: that handshake still completes. The consumer must ignore it.
- rst_n low mid-operation behaves like flush plus the reset values above.
- Undefined op values do not exist; all 8 encodings are legal.

## Timing
- Request handshake edge = cycle 0.
- Normal ops: BUSY for cycles 1..XLEN; out_valid is high from cycle XLEN+1.
  - XLEN=32: 33 cycles.
- Special cases: out_valid is high from cycle 1.
- No overlap: in_ready = 0 in BUSY and DONE. Back-to-back throughput is one operation per XLEN+2 cycles with out_ready held high.
- All outputs are registered; there is no combinational path from inputs to outputs except in_ready, which is a decode of state only.
- out_ready low: DONE holds indefinitely with no change to result.

## Test plan
- **MUL signed products:** MUL a=7, b=0xFFFFFFFD -> result 0xFFFFFFEB, out_valid at cycle 33. MULH a=b=0xFFFFFFFF -> 0x00000000.
- **MULHU / MULHSU:** MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE. MULHSU a=0xFFFFFFFF, b=0xFFFFFFFF -> 0xFFFFFFFF.
- **Signed divide:** DIV a=-7 (0xFFFFFFF9), b=2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. Both flags 0.
- **Divide by zero:** DIVU a=5, b=0 -> 0xFFFFFFFF with div_zero=1, out_valid at cycle 1. REMU with the same operands -> 5.
- **Signed overflow:** DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000 with div_ovf=1, out_valid at cycle 1. REM with the same operands -> 0.
- **Control:**
  - flush at cycle 10 of a DIV -> out_valid never rises; in_ready=1 at cycle 11.
  - out_ready held low 5 cycles in DONE -> result stable, in_ready stays 0.
  - rst_n low during BUSY -> all outputs at their reset values the next cycle.
  - XLEN=64 build: MULHU with all-ones operands -> 0xFFFFFFFFFFFFFFFE at cycle 65.

Source files
------------

// File: rtl/muldiv_seq.sv
// muldiv_seq: multi-cycle RV32M/RV64M multiply/divide unit.
//
// One result bit per cycle. A shift-add multiplier and a restoring divider
// share one 2*XLEN accumulator and one XLEN operand register. Divide-by-zero
// and signed overflow are resolved at accept time and go straight to DONE.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   request handshake (in_ready is a decode of IDLE)
//   op, a, b            funct3 opcode and rs1/rs2 operands
//   flush               abort any in-flight operation
//   out_valid/out_ready response handshake
//   result              product half, quotient or remainder
//   div_zero, div_ovf   corner-case flags, qualified by out_valid
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            div_zero,
    output logic            div_ovf
);

    localparam int CW = $clog2(XLEN + 1);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

    state_e              state_q;
    logic [CW-1:0]       cnt_q;
    logic [2:0]          op_q;
    logic [2*XLEN-1:0]   acc_q;    // mul: {partial hi, multiplier}; div: {remainder, dividend/quotient}
    logic [XLEN-1:0]     opnd_q;   // multiplicand or divisor magnitude
    logic                negq_q;   // negate product / quotient
    logic                negr_q;   // negate remainder (dividend sign)
    logic                out_valid_q;
    logic [XLEN-1:0]     result_q;
    logic                dz_q;
    logic                ov_q;

    // ---------------- accept-time decode ----------------
    logic            a_sgn, b_sgn, is_div, sp_dz, sp_ov;
    logic [XLEN-1:0] a_mag, b_mag, sp_res;

    always_comb begin
        is_div = op[2];
        a_sgn  = a[XLEN-1] & (op == OP_MULH || op == OP_MULHSU || op == OP_DIV || op == OP_REM);
        b_sgn  = b[XLEN-1] & (op == OP_MULH || op == OP_DIV || op == OP_REM);
        a_mag  = a_sgn ? (-a) : a;
        b_mag  = b_sgn ? (-b) : b;
        sp_dz  = is_div && (b == '0);
        // Signed overflow only for DIV/REM (op[0] == 0 among divides).
        sp_ov  = is_div && !op[0] && (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
        // op[1] selects remainder within the divide group.
        if (sp_dz)
            sp_res = op[1] ? a : '1;
        else
            sp_res = op[1] ? '0 : a;
    end

    // ---------------- one iteration of the shared datapath ----------------
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_sh;
    logic              div_ge;
    logic [XLEN-1:0]   div_rem;
    logic [2*XLEN-1:0] acc_d;

    always_comb begin
        // Multiply: add multiplicand when the current multiplier bit is set,
        // then shift the whole accumulator right, carry included.
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        // Divide: shift {rem, dividend} left one; the shifted remainder needs
        // XLEN+1 bits since it can reach 2*divisor-1.
        div_sh  = acc_q[2*XLEN-1:XLEN-1];
        div_ge  = (div_sh >= {1'b0, opnd_q});
        // When div_ge the true difference is below the divisor, so XLEN bits suffice.
        div_rem = div_ge ? (div_sh[XLEN-1:0] - opnd_q) : div_sh[XLEN-1:0];
        if (op_q[2])
            acc_d = {div_rem, acc_q[XLEN-2:0], div_ge};
        else
            acc_d = {mul_sum, acc_q[XLEN-1:1]};
    end

    // ---------------- sign correction and result select ----------------
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   quo, rem, fin_res;

    always_comb begin
        prod = negq_q ? (-acc_d) : acc_d;
        quo  = negq_q ? (-acc_d[XLEN-1:0]) : acc_d[XLEN-1:0];
        rem  = negr_q ? (-acc_d[2*XLEN-1:XLEN]) : acc_d[2*XLEN-1:XLEN];
        case (op_q)
            OP_MUL:                       fin_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: fin_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:              fin_res = quo;
            default:                      fin_res = rem;
        endcase
    end

    // ---------------- FSM with registered outputs ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            op_q        <= '0;
            acc_q       <= '0;
            opnd_q      <= '0;
            negq_q      <= 1'b0;
            negr_q      <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            dz_q        <= 1'b0;
            ov_q        <= 1'b0;
        end else if (flush) begin
            // Also wins over a same-cycle request; a same-cycle DONE handshake
            // completes anyway since both lead to IDLE.
            state_q     <= IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        op_q <= op;
                        if (sp_dz || sp_ov) begin
                            state_q     <= DONE;
                            out_valid_q <= 1'b1;
                            result_q    <= sp_res;
                            dz_q        <= sp_dz;
                            ov_q        <= sp_ov;
                        end else begin
                            state_q <= BUSY;
                            cnt_q   <= CW'(XLEN);
                            dz_q    <= 1'b0;
                            ov_q    <= 1'b0;
                            negq_q  <= a_sgn ^ b_sgn;
                            negr_q  <= a_sgn;
                            if (is_div) begin
                                acc_q  <= {{XLEN{1'b0}}, a_mag};
                                opnd_q <= b_mag;
                            end else begin
                                acc_q  <= {{XLEN{1'b0}}, b_mag};
                                opnd_q <= a_mag;
                            end
                        end
                    end
                end
                BUSY: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q     <= DONE;
                        out_valid_q <= 1'b1;
                        result_q    <= fin_res;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign div_zero  = dz_q;
    assign div_ovf   = ov_q;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: XLEN=32 instance for function/control,
// XLEN=64 instance for the wide MULHU case.
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, div_zero, div_ovf;
    logic [2:0]  op;
    logic [31:0] a, b, result;

    logic        in_valid64, in_ready64, out_valid64, div_zero64, div_ovf64;
    logic [2:0]  op64;
    logic [63:0] a64, b64, result64;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.XLEN(32)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .result(result), .div_zero(div_zero), .div_ovf(div_ovf)
    );

    muldiv_seq #(.XLEN(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid64), .in_ready(in_ready64),
        .op(op64), .a(a64), .b(b64), .flush(flush), .out_valid(out_valid64),
        .out_ready(out_ready), .result(result64), .div_zero(div_zero64), .div_ovf(div_ovf64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for out_valid (bounded), check, then complete
    // the handshake with out_ready high and check the unit is idle again.
    task automatic run(input string tag, input logic [2:0] o, input logic [31:0] aa,
                       input logic [31:0] bb, input logic [31:0] er,
                       input logic edz, input logic eov, input int elat);
        int cyc;
        op = o; a = aa; b = bb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(elat));
        chk({tag, " result"}, 64'(result), 64'(er));
        chk({tag, " flags"}, 64'({div_zero, div_ovf}), 64'({edz, eov}));
        @(posedge clk); #1;
        chk({tag, " idle"}, 64'({out_valid, in_ready}), 64'(2'b01));
    endtask

    initial begin
        int cyc;
        int seen;
        rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        op = '0; a = '0; b = '0;
        in_valid64 = 1'b0; op64 = '0; a64 = '0; b64 = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset outs", 64'({out_valid, in_ready, div_zero, div_ovf}), 64'(4'b0100));
        chk("reset result", 64'(result), 64'h0);
        rst_n = 1'b1;

        // Multiply family
        run("MUL 7*-3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1'b0, 1'b0, 33);
        run("MULH -1*-1",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 33);
        run("MULHU ones",    3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1'b0, 1'b0, 33);
        run("MULHSU ones",   3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 33);
        run("MULHU 2^31*2",  3'b011, 32'h80000000, 32'd2,        32'h00000001, 1'b0, 1'b0, 33);

        // Divide family
        run("DIV -7/2",      3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 1'b0, 1'b0, 33);
        run("REM -7/2",      3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 1'b0, 1'b0, 33);
        run("DIV 7/-2",      3'b100, 32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 1'b0, 1'b0, 33);
        run("REM 7/-2",      3'b110, 32'd7,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, 33);
        run("DIVU 100/7",    3'b101, 32'd100,      32'd7,        32'd14,       1'b0, 1'b0, 33);
        run("REMU 100/7",    3'b111, 32'd100,      32'd7,        32'd2,        1'b0, 1'b0, 33);
        run("DIVU big",      3'b101, 32'hFFFFFFFF, 32'h80000001, 32'd1,        1'b0, 1'b0, 33);
        run("REMU big",      3'b111, 32'hFFFFFFFF, 32'h80000001, 32'h7FFFFFFE, 1'b0, 1'b0, 33);

        // Corner cases
        run("DIVU 5/0",      3'b101, 32'd5,        32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1);
        run("REMU 5/0",      3'b111, 32'd5,        32'd0,        32'd5,        1'b1, 1'b0, 1);
        run("DIV -7/0",      3'b100, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFFF, 1'b1, 1'b0, 1);
        run("REM -7/0",      3'b110, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 1'b1, 1'b0, 1);
        run("DIV ovf",       3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b0, 1'b1, 1);
        run("REM ovf",       3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b1, 1);
        run("DIVU no ovf",   3'b101, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1'b0, 1'b0, 33);

        // Flush at cycle 10 of a DIV
        op = 3'b100; a = 32'd1000; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush idle", 64'({out_valid, in_ready}), 64'(2'b01));
        seen = 0;
        repeat (40) begin @(posedge clk); #1; if (out_valid) seen++; end
        chk("flush no out", 64'(seen), 64'h0);

        // Flush in the same cycle as a request: not accepted
        op = 3'b101; a = 32'd5; b = 32'd0; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        chk("flush+req", 64'({out_valid, in_ready}), 64'(2'b01));

        // out_ready held low in DONE
        out_ready = 1'b0;
        op = 3'b000; a = 32'd7; b = 32'hFFFFFFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 200) begin @(posedge clk); #1; cyc++; end
        chk("stall latency", 64'(cyc), 64'd33);
        repeat (5) begin
            @(posedge clk); #1;
            chk("stall result", 64'(result), 64'hFFFFFFEB);
            chk("stall state", 64'({out_valid, in_ready}), 64'(2'b10));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("stall release", 64'({out_valid, in_ready}), 64'(2'b01));

        // Reset during BUSY
        op = 3'b100; a = 32'hFFFFFFF9; b = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        chk("busy not ready", 64'(in_ready), 64'h0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        chk("midreset outs", 64'({out_valid, in_ready, div_zero, div_ovf}), 64'(4'b0100));
        chk("midreset result", 64'(result), 64'h0);
        rst_n = 1'b1;
        run("post reset DIV", 3'b100, 32'd20, 32'd4, 32'd5, 1'b0, 1'b0, 33);

        // XLEN=64 MULHU with all-ones operands
        op64 = 3'b011; a64 = '1; b64 = '1; in_valid64 = 1'b1;
        @(posedge clk); #1;
        in_valid64 = 1'b0;
        cyc = 1;
        while (!out_valid64 && cyc < 300) begin @(posedge clk); #1; cyc++; end
        chk("x64 latency", 64'(cyc), 64'd65);
        chk("x64 result", result64, 64'hFFFFFFFFFFFFFFFE);
        chk("x64 flags", 64'({div_zero64, div_ovf64}), 64'h0);
        @(posedge clk); #1;
        chk("x64 idle", 64'({out_valid64, in_ready64}), 64'(2'b01));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule
